imem_fetch_port: RTL and testbench
==================================

# imem_fetch_port

Parametrised instruction memory for the pipelined MIPS core, replacing the fixed 1K-word, hard-initialised array. It sits between the fetch stage and the program loader. It provides a registered, stall/flush-aware read port addressed by byte PC, plus a streaming load port for writing programs at run time. After reset it clears itself to NOP with a hardware sweep, and it flags misaligned or out-of-range fetches.

## Interface
- `DATA_W`, 32, instruction width in bits
- `DEPTH`, 1024, words of storage (power of two, ≥ 4)
- `ADDR_W`, 32, PC width in bits
- `IDX_W`, $clog2(DEPTH), derived word-index width (not overridden)
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — asynchronous, active-high reset
- `fetch_req` in 1 — fetch stage requests instruction at `pc`
- `pc` in ADDR_W — byte address
- `stall` in 1 — hold current output
- `flush` in 1 — kill the next output
- `instr` out DATA_W — fetched instruction (NOP when invalid)
- `instr_valid` out 1 — `instr` is valid this cycle
- `fetch_fault` out 1 — last request was misaligned or out of range
- `busy` out 1 — memory is in CLEAR or LOAD; fetches are ignored
- `load_start` in 1 — pulse: begin a program load at word 0
- `load_valid` in 1 — `load_data` is presented
- `load_data` in DATA_W — instruction word to write
- `load_last` in 1 — final beat of the load
- `load_ready` out 1 — a beat is accepted when `load_valid & load_ready`
- `load_count` out IDX_W+1 — words written by the current or last load

## Operation
- FSM states are CLEAR, READY and LOAD. `rst` forces CLEAR with the clear pointer at 0.
- CLEAR: writes NOP (32'h0000_0000) to word `ptr` each cycle and increments `ptr`. After writing word DEPTH-1 it goes to READY. Takes exactly DEPTH cycles.
- READY, fetch path:
  - `fetch_req` with no `stall` reads word `pc[IDX_W+1:2]`.
  - Fault if `pc[1:0]!=0` or `pc[ADDR_W-1:IDX_W+2]!=0`. A faulting fetch returns NOP with `instr_valid=0` and `fetch_fault=1`.
- READY, load entry: `load_start` moves to LOAD with `ptr=0` and `load_count=0`.
  - `load_start` takes priority over a same-cycle `fetch_req`. The fetch is dropped and produces no valid output.
- LOAD:
  - `load_ready=1`. Each accepted beat writes `load_data` to `ptr`, then increments `ptr` and `load_count`.
  - A beat with `load_last`, or a beat at `ptr==DEPTH-1`, returns to READY after the write.
  - `load_start` is ignored while in LOAD.
- `stall`: `instr`, `instr_valid` and `fetch_fault` hold their values, and no read is issued.
- `flush`: the next-cycle outputs are `instr=NOP`, `instr_valid=0` and `fetch_fault=0`. `flush` overrides `stall`.
- `busy=1` in CLEAR and LOAD. In those states `fetch_req` is ignored and outputs go NOP/invalid.
- Reset values:
  - `instr=0`, `instr_valid=0`, `fetch_fault=0`
  - `busy=1`, `load_ready=0`, `load_count=0`

## Timing
- Read latency is 1 cycle: a request at edge N appears on `instr`/`instr_valid` after edge N+1.
- Back-to-back fetches sustain one per cycle.
- Load write at edge N followed by a fetch at edge N+1 to the same word returns the new data (write-first).
- Last load beat at edge N: READY from edge N+1, and `busy` falls in the same cycle.
- Reset asserted mid-LOAD or mid-CLEAR:
  - All outputs go to their reset values immediately.
  - CLEAR restarts from word 0, and partially loaded contents are overwritten.

## Structure
- Package `imem_pkg` holds:
  - `IMEM_NOP` constant
  - `imem_state_t` enum {CLEAR, READY, LOAD}
  - `imem_fault_t` (aligned / misaligned / range), used only internally
- Sub-module `imem_sram`: DEPTH×DATA_W, one synchronous write port and one synchronous read port, write-first on address collision, no reset.
- The top level holds the FSM, pointer, fault decode and output register with stall/flush.

## Test plan
- Reset release: `busy=1` for exactly 1024 cycles. Then a fetch at `pc=0x3FC` returns 32'h0 with valid=1.
- Load 3 words 0x014A5020, 0x8C0A0020, 0x114A0003 (last on beat 3):
  - `load_count=3`, `busy` low the next cycle.
  - Fetches at pc 0, 4, 8 return those words in order, one per cycle.
- Misaligned `pc=0x6` gives `fetch_fault=1`, valid=0, instr=0. Out-of-range `pc=0x1000` gives the same response.
- Stall for 3 cycles after fetching pc=4 holds 0x8C0A0020 with valid=1. Stall with flush together gives valid=0 on the next cycle.
- `load_start` together with `fetch_req` in READY: no valid output, LOAD entered.
  - Loading 1024 beats without `load_last` auto-exits after beat 1024 with `load_count=1024`.
- Assert `rst` after 2 load beats: outputs reset asynchronously, CLEAR runs for 1024 cycles, and word 0 then reads back 0.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and types for the instruction memory.
//   IMEM_NOP      - encoding of the MIPS NOP (sll $0,$0,0)
//   imem_state_t  - controller states
//   imem_fault_t  - fetch address classification (internal)
//   classify_fault- turns the low PC bits and an out-of-range flag into a fault kind
package imem_pkg;

  localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    READY = 2'd1,
    LOAD  = 2'd2
  } imem_state_t;

  typedef enum logic [1:0] {
    FAULT_ALIGNED    = 2'd0,
    FAULT_MISALIGNED = 2'd1,
    FAULT_RANGE      = 2'd2
  } imem_fault_t;

  // Misalignment is reported ahead of range so a bad byte offset is never
  // masked by a high address.
  function automatic imem_fault_t classify_fault(input logic [1:0] lo, input logic hi_nz);
    if (lo != 2'b00) return FAULT_MISALIGNED;
    if (hi_nz)       return FAULT_RANGE;
    return FAULT_ALIGNED;
  endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// imem_fetch_port_if: fetch and program-load signals of the instruction memory.
//   master - fetch stage / loader side (drives requests and load beats)
//   slave  - memory side (drives instruction, status and load handshake)
interface imem_fetch_port_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 10
) ();
  // fetch side
  logic              fetch_req;
  logic [ADDR_W-1:0] pc;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              fetch_fault;
  logic              busy;
  // load side
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic [IDX_W:0]    load_count;

  modport master (
    output fetch_req, pc, stall, flush, load_start, load_valid, load_data, load_last,
    input  instr, instr_valid, fetch_fault, busy, load_ready, load_count
  );

  modport slave (
    input  fetch_req, pc, stall, flush, load_start, load_valid, load_data, load_last,
    output instr, instr_valid, fetch_fault, busy, load_ready, load_count
  );
endinterface

// File: rtl/imem_sram.sv
// imem_sram: DEPTH x DATA_W storage, one synchronous write port and one
// synchronous read port. No reset on contents or read register.
//   clk          - clock
//   we/waddr/wdata - write port
//   re/raddr     - read enable and address; rdata holds while re is low
//   rdata        - registered read data, write-first on address collision
module imem_sram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: parametrised instruction memory with a registered,
// stall/flush-aware fetch port and a streaming program-load port.
// After reset a hardware sweep fills every word with NOP (DEPTH cycles).
//   clk, rst - clock, asynchronous active-high reset
//   bus      - imem_fetch_port_if.slave: fetch (req/pc/stall/flush ->
//              instr/instr_valid/fetch_fault), busy, and load stream
//              (load_start/valid/data/last -> load_ready/load_count)
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  parameter  int ADDR_W = 32,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  imem_fetch_port_if.slave bus
);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] NOP_W    = DATA_W'(IMEM_NOP);

  imem_state_t       state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W:0]    load_count;
  logic              out_valid, out_fault, use_mem;

  imem_fault_t       fault;
  logic              fetch_ok, kill_out;
  logic              we;
  logic [DATA_W-1:0] wdata, rd_data;

  assign fault = classify_fault(bus.pc[1:0], |(bus.pc >> (IDX_W + 2)));

  // Outputs are forced idle on flush, while busy, and on the load_start
  // edge (the concurrent fetch is dropped).
  assign kill_out = bus.flush || (state != READY) || bus.load_start;
  assign fetch_ok = !kill_out && !bus.stall && bus.fetch_req && (fault == FAULT_ALIGNED);

  assign we    = (state == CLEAR) || ((state == LOAD) && bus.load_valid);
  assign wdata = (state == CLEAR) ? NOP_W : bus.load_data;

  imem_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_sram (
    .clk   (clk),
    .we    (we),
    .waddr (ptr),
    .wdata (wdata),
    .re    (fetch_ok),
    .raddr (bus.pc[IDX_W+1:2]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      ptr        <= '0;
      load_count <= '0;
      out_valid  <= 1'b0;
      out_fault  <= 1'b0;
      use_mem    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_IDX) state <= READY;
        end
        READY: begin
          if (bus.load_start) begin
            state      <= LOAD;
            ptr        <= '0;
            load_count <= '0;
          end
        end
        LOAD: begin
          if (bus.load_valid) begin
            ptr        <= ptr + 1'b1;
            load_count <= load_count + 1'b1;
            if (bus.load_last || (ptr == LAST_IDX)) state <= READY;
          end
        end
        default: state <= CLEAR;
      endcase

      // Stall leaves the output register and the SRAM read register
      // untouched (no read is issued), so instr holds for free.
      if (kill_out) begin
        out_valid <= 1'b0;
        out_fault <= 1'b0;
        use_mem   <= 1'b0;
      end else if (!bus.stall) begin
        out_valid <= fetch_ok;
        out_fault <= bus.fetch_req && (fault != FAULT_ALIGNED);
        use_mem   <= fetch_ok;
      end
    end
  end

  assign bus.instr       = use_mem ? rd_data : NOP_W;
  assign bus.instr_valid = out_valid;
  assign bus.fetch_fault = out_fault;
  assign bus.busy        = (state != READY);
  assign bus.load_ready  = (state == LOAD);
  assign bus.load_count  = load_count;
endmodule

// File: tb/tb_imem_fetch_port.sv
module tb_imem_fetch_port;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_fetch_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

  imem_fetch_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: memory contents and expected output triple
  logic [31:0] mdl [DEPTH];
  logic [31:0] e_instr;
  logic        e_valid, e_fault;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_req  = 1'b0;
    bus.pc         = '0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    e_instr = 32'h0; e_valid = 1'b0; e_fault = 1'b0;
  endtask

  // One READY-state fetch-port cycle, with the model advanced by the rules:
  // flush kills, stall holds, bad address faults, good address reads.
  task automatic fetch_cycle(input logic req, input logic [31:0] p,
                             input logic st, input logic fl);
    bus.fetch_req = req; bus.pc = p; bus.stall = st; bus.flush = fl;
    tick();
    if (fl) begin
      e_instr = 0; e_valid = 0; e_fault = 0;
    end else if (!st) begin
      if (!req) begin
        e_instr = 0; e_valid = 0; e_fault = 0;
      end else if ((p % 4 != 0) || (p >= DEPTH * 4)) begin
        e_instr = 0; e_valid = 0; e_fault = 1;
      end else begin
        e_instr = mdl[p / 4]; e_valid = 1; e_fault = 0;
      end
    end
    bus.fetch_req = 0; bus.stall = 0; bus.flush = 0;
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 5))
      0:       return ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
      1:       return 32'h1000 + ($urandom_range(0, 255) * 4);
      default: return $urandom_range(0, DEPTH - 1) * 4;
    endcase
  endfunction

  task automatic test_reset();
    int n;
    idle_inputs();
    rst = 1'b1;
    #3;
    total++;
    if ({bus.instr, bus.instr_valid, bus.fetch_fault, bus.busy, bus.load_ready, bus.load_count} !==
        {32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0}) begin
      bad++;
      $display("FAIL reset_values got instr=%h v=%b f=%b busy=%b rdy=%b cnt=%0d", bus.instr,
               bus.instr_valid, bus.fetch_fault, bus.busy, bus.load_ready, bus.load_count);
    end
    tick(); tick();
    rst = 1'b0;
    model_clear();
    n = 0;
    while (bus.busy && n < 2000) begin tick(); n++; end
    total++;
    if (n !== 1024) begin bad++; $display("FAIL clear_cycles got=%0d exp=1024", n); end
    fetch_cycle(1, 32'h3FC, 0, 0);
    total++;
    if ({bus.instr, bus.instr_valid, bus.fetch_fault} !== {32'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL fetch_3fc got instr=%h v=%b f=%b exp 0/1/0", bus.instr, bus.instr_valid, bus.fetch_fault);
    end
  endtask

  task automatic test_load_small();
    logic [31:0] prog [3] = '{32'h014A5020, 32'h8C0A0020, 32'h114A0003};
    bus.load_start = 1; tick(); bus.load_start = 0;
    total++;
    if ({bus.busy, bus.load_ready, bus.instr_valid} !== 3'b110) begin
      bad++; $display("FAIL load_entry got busy=%b rdy=%b v=%b", bus.busy, bus.load_ready, bus.instr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1; bus.load_data = prog[i]; bus.load_last = (i == 2);
      tick();
      mdl[i] = prog[i];
    end
    bus.load_valid = 0; bus.load_last = 0;
    e_instr = 0; e_valid = 0; e_fault = 0;
    total++;
    if ({bus.load_count, bus.busy, bus.load_ready} !== {11'd3, 1'b0, 1'b0}) begin
      bad++; $display("FAIL load3_done got cnt=%0d busy=%b rdy=%b exp 3/0/0",
                      bus.load_count, bus.busy, bus.load_ready);
    end
    for (int i = 0; i < 3; i++) begin
      fetch_cycle(1, i * 4, 0, 0);
      total++;
      if ({bus.instr, bus.instr_valid} !== {prog[i], 1'b1}) begin
        bad++; $display("FAIL load3_fetch%0d got=%h v=%b exp=%h", i, bus.instr, bus.instr_valid, prog[i]);
      end
    end
  endtask

  task automatic test_faults();
    logic [31:0] p;
    fetch_cycle(1, 32'h6, 0, 0);
    total++;
    if ({bus.instr, bus.instr_valid, bus.fetch_fault} !== {32'h0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL misaligned got instr=%h v=%b f=%b", bus.instr, bus.instr_valid, bus.fetch_fault);
    end
    fetch_cycle(1, 32'h1000, 0, 0);
    total++;
    if ({bus.instr, bus.instr_valid, bus.fetch_fault} !== {32'h0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL out_of_range got instr=%h v=%b f=%b", bus.instr, bus.instr_valid, bus.fetch_fault);
    end
    for (int i = 0; i < 12; i++) begin
      p = rand_pc();
      fetch_cycle(1, p, 0, 0);
      total++;
      if ({bus.instr, bus.instr_valid, bus.fetch_fault} !== {e_instr, e_valid, e_fault}) begin
        bad++; $display("FAIL rand_fault pc=%h got %h/%b/%b exp %h/%b/%b", p, bus.instr,
                        bus.instr_valid, bus.fetch_fault, e_instr, e_valid, e_fault);
      end
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] p;
    logic r, s, f;
    fetch_cycle(1, 32'h4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      fetch_cycle(1, 32'h8, 1, 0);
      total++;
      if ({bus.instr, bus.instr_valid} !== {32'h8C0A0020, 1'b1}) begin
        bad++; $display("FAIL stall_hold%0d got=%h v=%b exp 8c0a0020/1", i, bus.instr, bus.instr_valid);
      end
    end
    fetch_cycle(1, 32'h8, 1, 1);
    total++;
    if ({bus.instr, bus.instr_valid, bus.fetch_fault} !== {32'h0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL stall_flush got %h/%b/%b exp 0/0/0", bus.instr, bus.instr_valid, bus.fetch_fault);
    end
    for (int i = 0; i < 40; i++) begin
      p = rand_pc();
      r = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 5) == 0);
      fetch_cycle(r, p, s, f);
      total++;
      if ({bus.instr, bus.instr_valid, bus.fetch_fault} !== {e_instr, e_valid, e_fault}) begin
        bad++; $display("FAIL rand_mix%0d pc=%h got %h/%b/%b exp %h/%b/%b", i, p, bus.instr,
                        bus.instr_valid, bus.fetch_fault, e_instr, e_valid, e_fault);
      end
    end
  endtask

  task automatic test_full_load();
    int beats, cyc;
    logic v;
    logic [31:0] d, p;
    bus.fetch_req = 1; bus.pc = 32'h4; bus.load_start = 1;
    tick();
    bus.fetch_req = 0; bus.load_start = 0;
    total++;
    if ({bus.instr_valid, bus.load_ready, bus.busy} !== 3'b011) begin
      bad++; $display("FAIL start_prio got v=%b rdy=%b busy=%b exp 0/1/1", bus.instr_valid, bus.load_ready, bus.busy);
    end
    beats = 0; cyc = 0;
    while (beats < DEPTH && cyc < 5000) begin
      v = ($urandom_range(0, 3) != 0);
      d = $urandom();
      bus.load_valid = v; bus.load_data = d;
      bus.load_start = ($urandom_range(0, 15) == 0);
      bus.fetch_req = ($urandom_range(0, 1) == 1); bus.pc = 32'h0;
      tick();
      if (v) begin mdl[beats] = d; beats++; end
      cyc++;
      if (beats == 500) begin
        total++;
        if ({bus.instr_valid, bus.busy} !== 2'b01) begin
          bad++; $display("FAIL busy_fetch got v=%b busy=%b exp 0/1", bus.instr_valid, bus.busy);
        end
      end
    end
    idle_inputs();
    e_instr = 0; e_valid = 0; e_fault = 0;
    total++;
    if (cyc >= 5000) begin bad++; $display("FAIL load_timeout beats=%0d exp=1024", beats); end
    total++;
    if ({bus.load_count, bus.busy, bus.load_ready} !== {11'd1024, 1'b0, 1'b0}) begin
      bad++; $display("FAIL auto_exit got cnt=%0d busy=%b rdy=%b exp 1024/0/0",
                      bus.load_count, bus.busy, bus.load_ready);
    end
    for (int i = 0; i < 30; i++) begin
      p = (i == 0) ? 32'hFFC : rand_pc();
      fetch_cycle(1, p, 0, 0);
      total++;
      if ({bus.instr, bus.instr_valid, bus.fetch_fault} !== {e_instr, e_valid, e_fault}) begin
        bad++; $display("FAIL full_fetch pc=%h got %h/%b/%b exp %h/%b/%b", p, bus.instr,
                        bus.instr_valid, bus.fetch_fault, e_instr, e_valid, e_fault);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int n;
    fetch_cycle(1, 32'h0, 0, 0);
    bus.load_start = 1; tick(); bus.load_start = 0;
    for (int i = 0; i < 2; i++) begin
      bus.load_valid = 1; bus.load_data = 32'hDEAD_0000 + i; tick();
    end
    bus.load_data = 32'hBEEF_BEEF;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.instr, bus.instr_valid, bus.fetch_fault, bus.busy, bus.load_ready, bus.load_count} !==
        {32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0}) begin
      bad++; $display("FAIL async_reset got instr=%h v=%b f=%b busy=%b rdy=%b cnt=%0d", bus.instr,
                      bus.instr_valid, bus.fetch_fault, bus.busy, bus.load_ready, bus.load_count);
    end
    idle_inputs();
    tick();
    rst = 1'b0;
    model_clear();
    n = 0;
    while (bus.busy && n < 2000) begin tick(); n++; end
    total++;
    if (n !== 1024) begin bad++; $display("FAIL reclear_cycles got=%0d exp=1024", n); end
    for (int i = 0; i < 3; i++) begin
      fetch_cycle(1, i * 4, 0, 0);
      total++;
      if ({bus.instr, bus.instr_valid} !== {32'h0, 1'b1}) begin
        bad++; $display("FAIL reclear_word%0d got=%h v=%b exp 0/1", i, bus.instr, bus.instr_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_small();
    test_faults();
    test_stall_flush();
    test_full_load();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
